press_gesture_decoder: RTL and testbench

//  Consumes the conditioned button level and edge pulses from the input conditioner stage.

---
 rtl/press_gesture_decoder_pkg.sv | 19 +
 rtl/press_gesture_decoder_timer.sv | 33 +++
 rtl/press_gesture_decoder.sv | 116 +++++++++++
 tb/tb_press_gesture_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/press_gesture_decoder_pkg.sv
// Shared definitions for the press gesture decoder: state encoding and timer sizing.
package press_gesture_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HELD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } state_t;

  // Timer width: enough bits to reach the larger of the two terminal counts.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/press_gesture_decoder_timer.sv
// Shared gesture timer: synchronous-clear up-counter with LONG and DBL terminal-count flags.
module press_gesture_decoder_timer #(
  parameter int W       = 4,
  parameter int TC_LONG = 15,
  parameter int TC_DBL  = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic t_long,
  output logic t_dbl
);

  localparam logic [W-1:0] TC_L = W'(TC_LONG);
  localparam logic [W-1:0] TC_D = W'(TC_DBL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign t_long = (cnt == TC_L);
  assign t_dbl  = (cnt == TC_D);

endmodule

// File: rtl/press_gesture_decoder.sv
// Classifies conditioned button gestures into SHORT / LONG / DOUBLE pulses with a saturating count.
//
// state  | meaning
// IDLE   | no gesture in progress
// PRESS1 | first press down, timing toward LONG
// HELD   | long press reported, waiting for release
// GAP    | first press released, waiting for a second press
// PRESS2 | second press down, timing toward LONG
module press_gesture_decoder
  import press_gesture_decoder_pkg::*;
#(
  parameter int LONG_T = 16,
  parameter int DBL_T  = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cond,
  input  logic             rising,
  input  logic             falling,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic             holding,
  output logic             busy,
  output logic [CNT_W-1:0] gesture_count
);

  localparam int TW = clog2_max(LONG_T, DBL_T);

  state_t state, nxt;
  logic   t_long, t_dbl;
  logic   rise_ok, fall_ok;
  logic   fire_short, fire_long, fire_dbl;
  logic   tmr_clr, tmr_en;

  // Simultaneous rising and falling is a protocol violation: treat as no edge at all.
  assign rise_ok = rising & ~falling;
  assign fall_ok = falling & ~rising;

  always_comb begin
    nxt        = state;
    fire_short = 1'b0;
    fire_long  = 1'b0;
    fire_dbl   = 1'b0;
    case (state)
      ST_IDLE:   if (rise_ok) nxt = ST_PRESS1;
      ST_PRESS1: begin
        if (fall_ok) begin
          nxt = ST_GAP;
        end else if (t_long) begin
          nxt       = cond ? ST_HELD : ST_IDLE;
          fire_long = cond;
        end
      end
      ST_HELD:   if (fall_ok) nxt = ST_IDLE;
      ST_GAP: begin
        if (rise_ok) begin
          nxt = ST_PRESS2;
        end else if (t_dbl) begin
          nxt        = ST_IDLE;
          fire_short = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall_ok) begin
          nxt      = ST_IDLE;
          fire_dbl = 1'b1;
        end else if (t_long) begin
          nxt       = cond ? ST_HELD : ST_IDLE;
          fire_long = cond;
        end
      end
      default:   nxt = ST_IDLE;
    endcase
  end

  assign tmr_clr = (nxt != state);
  assign tmr_en  = (state == ST_PRESS1) || (state == ST_GAP) || (state == ST_PRESS2);

  press_gesture_decoder_timer #(
    .W       (TW),
    .TC_LONG (LONG_T - 1),
    .TC_DBL  (DBL_T - 1)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .t_long (t_long),
    .t_dbl  (t_dbl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
      holding       <= 1'b0;
      busy          <= 1'b0;
      gesture_count <= '0;
    end else begin
      state        <= nxt;
      short_press  <= fire_short;
      long_press   <= fire_long;
      double_press <= fire_dbl;
      holding      <= (nxt == ST_HELD);
      busy         <= (nxt != ST_IDLE);
      if ((fire_short | fire_long | fire_dbl) && (gesture_count != '1)) begin
        gesture_count <= gesture_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_press_gesture_decoder.sv
// Directed bench for press_gesture_decoder with a per-cycle gesture model and literal spot checks.
module tb_press_gesture_decoder;

  localparam int LONG_T = 16;
  localparam int DBL_T  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cond = 1'b0, rising = 1'b0, falling = 1'b0;

  logic       sp_a, lp_a, dp_a, hold_a, busy_a;
  logic [7:0] cnt_a;
  logic       sp_b, lp_b, dp_b, hold_b, busy_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  press_gesture_decoder #(.LONG_T(LONG_T), .DBL_T(DBL_T), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .cond(cond), .rising(rising), .falling(falling),
    .short_press(sp_a), .long_press(lp_a), .double_press(dp_a),
    .holding(hold_a), .busy(busy_a), .gesture_count(cnt_a)
  );

  press_gesture_decoder #(.LONG_T(LONG_T), .DBL_T(DBL_T), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cond(cond), .rising(rising), .falling(falling),
    .short_press(sp_b), .long_press(lp_b), .double_press(dp_b),
    .holding(hold_b), .busy(busy_b), .gesture_count(cnt_b)
  );

  // Model: phase 0 none, 1 first press down, 2 released waiting, 3 second press down, 4 long held.
  // m_age counts clock edges spent in the current phase.
  int   m_ph, m_age, m_cnt_a, m_cnt_b;
  logic m_sp, m_lp, m_dp, m_hold, m_busy;

  always @(posedge clk or negedge rst_n) begin : model
    int   ph, ag;
    logic s, l, d, r, f;
    if (!rst_n) begin
      m_ph <= 0; m_age <= 0; m_cnt_a <= 0; m_cnt_b <= 0;
      m_sp <= 0; m_lp <= 0; m_dp <= 0; m_hold <= 0; m_busy <= 0;
    end else begin
      ph = m_ph; ag = m_age + 1;
      s = 0; l = 0; d = 0;
      r = rising && !falling;
      f = falling && !rising;
      case (ph)
        0: begin ag = 0; if (r) ph = 1; end
        1: if (f) begin ph = 2; ag = 0; end
           else if (ag == LONG_T) begin l = cond; ph = cond ? 4 : 0; ag = 0; end
        2: if (r) begin ph = 3; ag = 0; end
           else if (ag == DBL_T) begin s = 1; ph = 0; ag = 0; end
        3: if (f) begin d = 1; ph = 0; ag = 0; end
           else if (ag == LONG_T) begin l = cond; ph = cond ? 4 : 0; ag = 0; end
        default: begin ag = 0; if (f) ph = 0; end
      endcase
      m_ph <= ph; m_age <= ag;
      m_sp <= s; m_lp <= l; m_dp <= d;
      m_hold <= (ph == 4);
      m_busy <= (ph != 0);
      if ((s || l || d) && m_cnt_a < 255) m_cnt_a <= m_cnt_a + 1;
      if ((s || l || d) && m_cnt_b < 3)   m_cnt_b <= m_cnt_b + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_short_a", 32'(sp_a), 32'(m_sp));
      chk("m_long_a", 32'(lp_a), 32'(m_lp));
      chk("m_double_a", 32'(dp_a), 32'(m_dp));
      chk("m_holding_a", 32'(hold_a), 32'(m_hold));
      chk("m_busy_a", 32'(busy_a), 32'(m_busy));
      chk("m_count_a", 32'(cnt_a), 32'(m_cnt_a));
      chk("m_short_b", 32'(sp_b), 32'(m_sp));
      chk("m_busy_b", 32'(busy_b), 32'(m_busy));
      chk("m_count_b", 32'(cnt_b), 32'(m_cnt_b));
    end
  end

  task automatic drive(input logic c, input logic r, input logic f);
    cond = c; rising = r; falling = f;
    @(posedge clk);
    #2;
  endtask

  task automatic press_start();
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic hold_n(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic rel();
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic short_gesture();
    press_start(); hold_n(1); rel(); idle_n(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_n(2);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_pulses", 32'({sp_a, lp_a, dp_a, hold_a}), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_n(2);

    // 1: short press
    press_start(); hold_n(4); rel(); idle_n(7);
    chk("t1_short_early", 32'(sp_a), 0);
    idle_n(1);
    chk("t1_short", 32'(sp_a), 1);
    chk("t1_count", 32'(cnt_a), 1);
    idle_n(1);
    chk("t1_short_once", 32'(sp_a), 0);
    chk("t1_idle", 32'(busy_a), 0);

    // 2: long press
    press_start(); hold_n(15);
    chk("t2_long_early", 32'(lp_a), 0);
    hold_n(1);
    chk("t2_long", 32'(lp_a), 1);
    chk("t2_holding", 32'(hold_a), 1);
    chk("t2_count", 32'(cnt_a), 2);
    hold_n(4);
    chk("t2_long_once", 32'(lp_a), 0);
    chk("t2_still_holding", 32'(hold_a), 1);
    rel();
    chk("t2_release", 32'({hold_a, busy_a, sp_a, lp_a}), 0);
    idle_n(2);

    // 3: double press
    press_start(); hold_n(2); rel(); idle_n(3);
    press_start(); hold_n(2); rel();
    chk("t3_double", 32'(dp_a), 1);
    chk("t3_count", 32'(cnt_a), 3);
    idle_n(10);
    chk("t3_no_short", 32'(cnt_a), 3);

    // 4a: second rising exactly at gap terminal count
    press_start(); hold_n(1); rel(); idle_n(7);
    press_start();
    chk("t4_rise_at_tdbl_short", 32'(sp_a), 0);
    chk("t4_rise_at_tdbl_busy", 32'(busy_a), 1);
    rel();
    chk("t4_double", 32'(dp_a), 1);
    chk("t4_count_dbl", 32'(cnt_a), 4);
    idle_n(2);

    // 4b: falling exactly at long terminal count
    press_start(); hold_n(15); rel();
    chk("t4_fall_at_tlong_long", 32'(lp_a), 0);
    chk("t4_fall_at_tlong_gap", 32'({busy_a, hold_a}), 2);
    idle_n(8);
    chk("t4_short_after", 32'(sp_a), 1);
    chk("t4_count", 32'(cnt_a), 5);
    idle_n(2);

    // 5: asynchronous reset in the middle of the second press
    press_start(); hold_n(1); rel(); idle_n(2);
    press_start(); hold_n(3);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_a", 32'({sp_a, lp_a, dp_a, hold_a, busy_a}), 0);
    chk("t5_rst_count_a", 32'(cnt_a), 0);
    chk("t5_rst_b", 32'({busy_b, cnt_b}), 0);
    idle_n(2);
    rst_n = 1'b1;
    idle_n(1);
    press_start(); hold_n(4); rel(); idle_n(8);
    chk("t5_clean_short", 32'(sp_a), 1);
    chk("t5_clean_count", 32'(cnt_a), 1);

    // 6: saturation of the 2-bit counter
    do_reset();
    idle_n(1);
    for (int i = 1; i <= 5; i++) begin
      short_gesture();
      chk("t6_sat_count", 32'(cnt_b), (i < 3) ? i : 3);
    end
    drive(1'b0, 1'b0, 1'b1);
    chk("t6_stray_fall_busy", 32'(busy_a), 0);
    chk("t6_stray_fall_count", 32'(cnt_b), 3);
    chk("t6_wide_count", 32'(cnt_a), 5);
    idle_n(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
